id_forward_hazard_unit: RTL and testbench
=========================================

Name: id_forward_hazard_unit

Overview:
- Parametrised successor to the ID-stage forwarding unit. Resolves branch and jr operands in ID by forwarding from any later pipeline stage.
- Owns an internal tag pipeline that records which destination register each in-flight instruction will write. Callers no longer supply MEM_RD/WB_RD by hand.
- Generates load-use and early-operand stalls, and keeps a saturating stall-cycle counter.
- Sits between the decoder/register file and the ID/EX register.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width.
- NUM_STG, 3, number of tracked post-ID stages. Stage 0 = EX, 1 = MEM, NUM_STG-1 = WB.
- LOAD_RDY, 2, first stage index at which load data is forwardable.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- pipe_hold  in  1  global freeze (memory wait); nothing shifts
- ex_flush  in  1  squash the instruction entering EX
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW  source registers
- id_use_rs, id_use_rt  in  1  operand is actually read
- id_early  in  1  operands consumed in ID (beq/bne/jr)
- id_rd  in  REG_AW  destination of the ID instruction
- id_wen  in  1  ID instruction writes a register
- id_is_load  in  1  ID instruction is a load
- rf_rs_data, rf_rt_data  in  DATA_W  register file read data
- stg_data  in  (NUM_STG-1)*DATA_W  result buses of stages 1..NUM_STG-1, packed with stage 1 in the LSBs
- rs_data, rt_data  out  DATA_W  resolved operand values
- fwd_src_rs, fwd_src_rt  out  clog2(NUM_STG+1)  0 = register file, k = stage k-1
- stall  out  1  hold PC and IF/ID, insert bubble into EX
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Tag pipeline: NUM_STG entries of {rd, wen, is_load}, registered on clk.
- On reset: all entries cleared to wen=0. stall_cnt=0. Combinational outputs settle to stall=0, fwd_src=0, rs_data/rt_data = register file data.
- Each clock edge:
  - pipe_hold=1: all entries and stall_cnt hold.
  - Otherwise entries shift one stage toward WB; the WB entry is discarded.
  - EX entry loads {id_rd, id_wen & id_valid & (id_rd!=0), id_is_load}.
  - If stall=1 or ex_flush=1, the EX entry gets wen=0 (bubble) instead.
- Match rule: operand r matches stage k when entry[k].wen and entry[k].rd == r. r == 0 never matches.
- Priority: the youngest (lowest k) matching stage wins. Older matches are ignored even when ready.
- Readiness of the winning entry: not ready when k==0, or when is_load and k < LOAD_RDY. Otherwise ready.
- Stall condition (evaluated per operand, OR-ed over rs and rt; gated by id_valid and id_use_x):
  - id_early=1 and the winning entry is not ready; or
  - id_early=0, winning k==0, and entry[0].is_load (classic load-use).
- Forwarding (combinational): winning entry ready and k>=1 → data = stg_data slice k-1, fwd_src = k+1. Otherwise register file data, fwd_src = 0. With id_early=0 and winning k==0 on a non-load, fwd_src=0 because EX-stage forwarding handles that case.
- Resulting stall cycles, default params:
  - ALU result → beq: 1 cycle.
  - lw → beq: 2 cycles.
  - lw → add: 1 cycle.
  - ALU → add: 0 cycles.
- stall_cnt increments on each edge where stall=1 and pipe_hold=0. It saturates at all-ones.
- Simultaneous events: pipe_hold dominates flush and stall. flush plus stall yields a single bubble. WB entry matching with same-cycle register file write forwards from WB, so no write-through dependency.
- Reset asserted mid-stall clears the tags immediately (async). stall drops in the same cycle.

Decomposition:
- Shared package: stage index constants (STG_EX=0, STG_MEM=1, STG_WB), FWD_SRC_RF=0, and the tag entry struct/field widths.
- Sub-module: id_fwd_operand_sel, instantiated twice (rs, rt). It does the priority match, readiness check, data mux and per-operand stall term.

Test Plan:
- Reset then id_rs=3, use_rs=1, early=1, rf_rs_data=0x11 with no prior writers → stall=0, fwd_src_rs=0, rs_data=0x11.
- Issue add r5; next cycle beq r5,r0 → stall=1 for exactly 1 cycle. Then fwd_src_rs=2 (MEM), rs_data = MEM slice 0x12345678, stall_cnt=1.
- Issue lw r7; next cycle beq r7 → stall 2 cycles. Then fwd_src=3 (WB) with data 0xABCDEF12, stall_cnt=2. Repeat with add r9,r7 → 1 stall.
- Stage 1 and stage 2 both hold rd=4 → MEM wins. Write to r0 in flight → never forwarded, fwd_src=0.
- pipe_hold=1 during a stall → tags frozen, stall_cnt unchanged. ex_flush on add r5 → later beq r5 has no stall.
- Assert rst mid lw→beq stall → stall=0 within the reset cycle, stall_cnt=0. Force stall for 2^CNT_W+3 cycles → stall_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/id_forward_hazard_unit_pkg.sv
// Shared constants and tag-entry layout for the ID-stage forwarding/hazard unit.
// A tag entry is packed as {rd, wen, is_load}, is_load in bit 0.
package id_forward_hazard_unit_pkg;

    localparam int STG_EX     = 0;
    localparam int STG_MEM    = 1;
    localparam int FWD_SRC_RF = 0;

    localparam int TAG_LOAD_BIT = 0;
    localparam int TAG_WEN_BIT  = 1;
    localparam int TAG_RD_LSB   = 2;

    // Width of one packed tag entry for a given register address width.
    function automatic int tag_w(input int reg_aw);
        return reg_aw + 2;
    endfunction

    // WB is always the oldest tracked stage.
    function automatic int stg_wb(input int num_stg);
        return num_stg - 1;
    endfunction

endpackage

// File: rtl/id_forward_hazard_unit_operand_sel.sv
// Per-operand resolver: youngest-match priority, readiness, data mux and stall term.
module id_fwd_operand_sel
    import id_forward_hazard_unit_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int NUM_STG  = 3,
    parameter int LOAD_RDY = 2
) (
    input  logic [NUM_STG*(REG_AW+2)-1:0] i_tags,
    input  logic [REG_AW-1:0]             i_reg,
    input  logic                          i_use,
    input  logic                          i_id_valid,
    input  logic                          i_early,
    input  logic [DATA_W-1:0]             i_rf_data,
    input  logic [(NUM_STG-1)*DATA_W-1:0] i_stg_data,
    output logic [DATA_W-1:0]             o_data,
    output logic [$clog2(NUM_STG+1)-1:0]  o_src,
    output logic                          o_stall
);

    localparam int TAG_W = tag_w(REG_AW);
    localparam int FWD_W = $clog2(NUM_STG + 1);

    logic w_hit;
    int   w_win;
    logic w_win_load;
    logic w_ready;

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        w_hit      = 1'b0;
        w_win      = STG_EX;
        w_win_load = 1'b0;
        for (int k = NUM_STG - 1; k >= 0; k--) begin
            if (i_tags[k*TAG_W + TAG_WEN_BIT] &&
                (i_tags[k*TAG_W + TAG_RD_LSB +: REG_AW] == i_reg) &&
                (i_reg != '0)) begin
                w_hit      = 1'b1;
                w_win      = k;
                w_win_load = i_tags[k*TAG_W + TAG_LOAD_BIT];
            end
        end
    end

    assign w_ready = w_hit && (w_win != STG_EX) && !(w_win_load && (w_win < LOAD_RDY));

    assign o_stall = i_id_valid && i_use && w_hit &&
                     (i_early ? !w_ready : ((w_win == STG_EX) && w_win_load));

    always_comb begin
        o_data = i_rf_data;
        o_src  = FWD_W'(FWD_SRC_RF);
        if (w_ready) begin
            for (int k = STG_MEM; k < NUM_STG; k++) begin
                if (k == w_win) begin
                    o_data = i_stg_data[(k-1)*DATA_W +: DATA_W];
                    o_src  = FWD_W'(k + 1);
                end
            end
        end
    end

endmodule

// File: rtl/id_forward_hazard_unit.sv
// ID-stage forwarding and hazard unit with its own destination-tag pipeline
// and a saturating stall-cycle counter.
module id_forward_hazard_unit
    import id_forward_hazard_unit_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int NUM_STG  = 3,
    parameter int LOAD_RDY = 2,
    parameter int CNT_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pipe_hold,
    input  logic                          ex_flush,
    input  logic                          id_valid,
    input  logic [REG_AW-1:0]             id_rs,
    input  logic [REG_AW-1:0]             id_rt,
    input  logic                          id_use_rs,
    input  logic                          id_use_rt,
    input  logic                          id_early,
    input  logic [REG_AW-1:0]             id_rd,
    input  logic                          id_wen,
    input  logic                          id_is_load,
    input  logic [DATA_W-1:0]             rf_rs_data,
    input  logic [DATA_W-1:0]             rf_rt_data,
    input  logic [(NUM_STG-1)*DATA_W-1:0] stg_data,
    output logic [DATA_W-1:0]             rs_data,
    output logic [DATA_W-1:0]             rt_data,
    output logic [$clog2(NUM_STG+1)-1:0]  fwd_src_rs,
    output logic [$clog2(NUM_STG+1)-1:0]  fwd_src_rt,
    output logic                          stall,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam int TAG_W = tag_w(REG_AW);

    logic [TAG_W-1:0]         r_tag [NUM_STG];
    logic [CNT_W-1:0]         r_stall_cnt;
    logic [NUM_STG*TAG_W-1:0] w_tags_flat;
    logic [TAG_W-1:0]         w_ex_entry;
    logic                     w_stall_rs;
    logic                     w_stall_rt;

    always_comb begin
        w_tags_flat = '0;
        for (int k = 0; k < NUM_STG; k++) begin
            w_tags_flat[k*TAG_W +: TAG_W] = r_tag[k];
        end
    end

    // A stalled or flushed ID instruction enters EX as an all-zero bubble.
    always_comb begin
        w_ex_entry = '0;
        if (!stall && !ex_flush) begin
            w_ex_entry[TAG_RD_LSB +: REG_AW] = id_rd;
            w_ex_entry[TAG_WEN_BIT]          = id_wen && id_valid && (id_rd != '0);
            w_ex_entry[TAG_LOAD_BIT]         = id_is_load;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_STG; k++) begin
                r_tag[k] <= '0;
            end
        end else if (!pipe_hold) begin
            for (int k = stg_wb(NUM_STG); k > STG_EX; k--) begin
                r_tag[k] <= r_tag[k-1];
            end
            r_tag[STG_EX] <= w_ex_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!pipe_hold && stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    id_fwd_operand_sel #(
        .DATA_W   (DATA_W),
        .REG_AW   (REG_AW),
        .NUM_STG  (NUM_STG),
        .LOAD_RDY (LOAD_RDY)
    ) u_sel_rs (
        .i_tags     (w_tags_flat),
        .i_reg      (id_rs),
        .i_use      (id_use_rs),
        .i_id_valid (id_valid),
        .i_early    (id_early),
        .i_rf_data  (rf_rs_data),
        .i_stg_data (stg_data),
        .o_data     (rs_data),
        .o_src      (fwd_src_rs),
        .o_stall    (w_stall_rs)
    );

    id_fwd_operand_sel #(
        .DATA_W   (DATA_W),
        .REG_AW   (REG_AW),
        .NUM_STG  (NUM_STG),
        .LOAD_RDY (LOAD_RDY)
    ) u_sel_rt (
        .i_tags     (w_tags_flat),
        .i_reg      (id_rt),
        .i_use      (id_use_rt),
        .i_id_valid (id_valid),
        .i_early    (id_early),
        .i_rf_data  (rf_rt_data),
        .i_stg_data (stg_data),
        .o_data     (rt_data),
        .o_src      (fwd_src_rt),
        .o_stall    (w_stall_rt)
    );

    assign stall     = w_stall_rs || w_stall_rt;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_forward_hazard_unit.sv
// Self-checking bench for id_forward_hazard_unit: scripted pipeline scenarios,
// expected outputs queued per cycle and compared on the falling edge.
module tb_id_forward_hazard_unit;

    localparam logic [31:0] RF_RS = 32'h0000_0011;
    localparam logic [31:0] RF_RT = 32'h0000_0022;
    localparam logic [31:0] MEM_D = 32'h1234_5678;
    localparam logic [31:0] WB_D  = 32'hABCD_EF12;
    localparam int          EXP_W = 85;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_hold, ex_flush, id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_use_rs, id_use_rt, id_early, id_wen, id_is_load;
    logic [31:0] rf_rs_data, rf_rt_data;
    logic [63:0] stg_data;
    logic [31:0] rs_data, rt_data;
    logic [1:0]  fwd_src_rs, fwd_src_rt;
    logic        stall;
    logic [15:0] stall_cnt;

    logic [31:0] sat_rs_data, sat_rt_data;
    logic [1:0]  sat_src_rs, sat_src_rt;
    logic        sat_stall;
    logic [3:0]  sat_cnt;

    logic [EXP_W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_forward_hazard_unit dut (
        .clk(clk), .rst(rst), .pipe_hold(pipe_hold), .ex_flush(ex_flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_early(id_early),
        .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load),
        .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .stg_data(stg_data),
        .rs_data(rs_data), .rt_data(rt_data),
        .fwd_src_rs(fwd_src_rs), .fwd_src_rt(fwd_src_rt),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    id_forward_hazard_unit #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .pipe_hold(pipe_hold), .ex_flush(ex_flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_early(id_early),
        .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load),
        .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .stg_data(stg_data),
        .rs_data(sat_rs_data), .rt_data(sat_rt_data),
        .fwd_src_rs(sat_src_rs), .fwd_src_rt(sat_src_rt),
        .stall(sat_stall), .stall_cnt(sat_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic use_rs,
                          input logic [4:0] rt, input logic use_rt, input logic early,
                          input logic [4:0] rd, input logic wen, input logic ld);
        id_valid = v;  id_rs = rs;  id_use_rs = use_rs;  id_rt = rt;  id_use_rt = use_rt;
        id_early = early;  id_rd = rd;  id_wen = wen;  id_is_load = ld;
    endtask

    task automatic compare_head();
        logic [EXP_W-1:0] e;
        check("sb_depth", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stall",     {63'd0, stall}, {63'd0, e[84]});
            check("src_rs",    {62'd0, fwd_src_rs}, {62'd0, e[83:82]});
            check("rs_data",   {32'd0, rs_data}, {32'd0, e[81:50]});
            check("src_rt",    {62'd0, fwd_src_rt}, {62'd0, e[49:48]});
            check("rt_data",   {32'd0, rt_data}, {32'd0, e[47:16]});
            check("stall_cnt", {48'd0, stall_cnt}, {48'd0, e[15:0]});
        end
    endtask

    // Queue one cycle of expected outputs, compare mid-cycle, then let the edge happen.
    task automatic expect_cycle(input logic e_stall, input logic [1:0] e_src_rs,
                                input logic [31:0] e_rs, input logic [1:0] e_src_rt,
                                input logic [31:0] e_rt, input logic [15:0] e_cnt);
        exp_q.push_back({e_stall, e_src_rs, e_rs, e_src_rt, e_rt, e_cnt});
        @(negedge clk);
        compare_head();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rs(input logic e_stall, input logic [1:0] e_src,
                             input logic [31:0] e_rs, input logic [15:0] e_cnt);
        expect_cycle(e_stall, e_src, e_rs, 2'd0, RF_RT, e_cnt);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        pipe_hold = 1'b0;
        ex_flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int exp_cnt;
        logic e_stall;
        rf_rs_data = RF_RS;
        rf_rt_data = RF_RT;
        stg_data   = {WB_D, MEM_D};

        // Reset state and no-writer read
        reset_dut();
        expect_rs(0, 0, RF_RS, 0);
        set_id(1, 3, 1, 0, 0, 1, 0, 0, 0);
        expect_rs(0, 0, RF_RS, 0);

        // ALU -> beq: one stall, then MEM forward
        set_id(1, 0, 0, 0, 0, 0, 5, 1, 0);
        expect_rs(0, 0, RF_RS, 0);
        set_id(1, 5, 1, 0, 1, 1, 0, 0, 0);
        expect_rs(1, 0, RF_RS, 0);
        expect_rs(0, 2, MEM_D, 1);

        // lw -> beq: two stalls, then WB forward
        reset_dut();
        set_id(1, 0, 0, 0, 0, 0, 7, 1, 1);
        expect_rs(0, 0, RF_RS, 0);
        set_id(1, 7, 1, 0, 0, 1, 0, 0, 0);
        expect_rs(1, 0, RF_RS, 0);
        expect_rs(1, 0, RF_RS, 1);
        expect_rs(0, 3, WB_D, 2);

        // lw -> add: one stall; ALU -> add: none
        reset_dut();
        set_id(1, 0, 0, 0, 0, 0, 7, 1, 1);
        expect_rs(0, 0, RF_RS, 0);
        set_id(1, 7, 1, 0, 0, 0, 9, 1, 0);
        expect_rs(1, 0, RF_RS, 0);
        expect_rs(0, 0, RF_RS, 1);
        set_id(1, 9, 1, 0, 0, 0, 10, 1, 0);
        expect_rs(0, 0, RF_RS, 1);

        // MEM and WB both write r4: MEM wins; r0 writes never forward
        reset_dut();
        set_id(1, 0, 0, 0, 0, 0, 4, 1, 0);
        expect_rs(0, 0, RF_RS, 0);
        expect_rs(0, 0, RF_RS, 0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_rs(0, 0, RF_RS, 0);
        set_id(1, 0, 1, 4, 1, 1, 0, 0, 0);
        expect_cycle(0, 0, RF_RS, 2, MEM_D, 0);
        set_id(1, 0, 0, 0, 0, 0, 0, 1, 0);
        expect_rs(0, 0, RF_RS, 0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_rs(0, 0, RF_RS, 0);
        set_id(1, 0, 1, 0, 1, 1, 0, 0, 0);
        expect_cycle(0, 0, RF_RS, 0, RF_RT, 0);

        // pipe_hold freezes tags and counter during a stall
        reset_dut();
        set_id(1, 0, 0, 0, 0, 0, 5, 1, 0);
        expect_rs(0, 0, RF_RS, 0);
        set_id(1, 5, 1, 0, 0, 1, 0, 0, 0);
        pipe_hold = 1'b1;
        expect_rs(1, 0, RF_RS, 0);
        expect_rs(1, 0, RF_RS, 0);
        pipe_hold = 1'b0;
        expect_rs(1, 0, RF_RS, 0);
        expect_rs(0, 2, MEM_D, 1);

        // Flushed producer leaves no dependency
        reset_dut();
        set_id(1, 0, 0, 0, 0, 0, 5, 1, 0);
        ex_flush = 1'b1;
        expect_rs(0, 0, RF_RS, 0);
        ex_flush = 1'b0;
        set_id(1, 5, 1, 0, 0, 1, 0, 0, 0);
        expect_rs(0, 0, RF_RS, 0);

        // Reset in the middle of a lw -> beq stall
        reset_dut();
        set_id(1, 0, 0, 0, 0, 0, 7, 1, 1);
        expect_rs(0, 0, RF_RS, 0);
        set_id(1, 7, 1, 0, 0, 1, 0, 0, 0);
        expect_rs(1, 0, RF_RS, 0);
        expect_rs(1, 0, RF_RS, 1);
        rst = 1'b1;
        expect_rs(0, 0, RF_RS, 0);
        rst = 1'b0;
        expect_rs(0, 0, RF_RS, 0);

        // Self-sustaining lw r7 <- r7 (early): stall, stall, issue, repeating
        reset_dut();
        set_id(1, 7, 1, 0, 0, 1, 7, 1, 1);
        exp_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            e_stall = (i % 3 != 0);
            if (i >= 3 && i % 3 == 0)
                expect_rs(0, 3, WB_D, 16'(exp_cnt));
            else
                expect_rs(e_stall, 0, RF_RS, 16'(exp_cnt));
            if (e_stall) exp_cnt++;
        end
        check("cnt_total", {48'd0, stall_cnt}, 64'd20);
        check("cnt_saturate", {60'd0, sat_cnt}, 64'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
